// File: rtl/ram_mp_if.sv
// Bus bundle for the N-port RAM: per-port write enables, addresses and data,
// plus the clear request and the ready/collide status.
interface ram_mp_if #(
  parameter int NPORTS = 2,
  parameter int AW     = 15,
  parameter int DW     = 8
) ();
  logic                 clr_req;
  logic [NPORTS-1:0]    we;
  logic [NPORTS*AW-1:0] addr;
  logic [NPORTS*DW-1:0] data_in;
  logic [NPORTS*DW-1:0] data_out;
  logic                 ready;
  logic                 collide;

  modport master (
    output clr_req, we, addr, data_in,
    input  data_out, ready, collide
  );

  modport slave (
    input  clr_req, we, addr, data_in,
    output data_out, ready, collide
  );
endinterface

// File: rtl/ram_mp.sv
// N-port synchronous RAM with read-old-data ports, same-address write collision
// flag and a zero-fill state machine run after reset or on request.
module ram_mp #(
  parameter int AW         = 15,
  parameter int DW         = 8,
  parameter int NPORTS     = 2,
  parameter int CLR_ON_RST = 1
) (
  input  logic    clk,
  input  logic    rst,
  ram_mp_if.slave bus
);
  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_CLEAR = 1'b1} state_e;

  localparam int            DEPTH     = 2 ** AW;
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};
  localparam state_e        RST_STATE = (CLR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
  localparam logic          RST_READY = (CLR_ON_RST != 0) ? 1'b0 : 1'b1;

  logic [DW-1:0]        mem_q [DEPTH];
  state_e               state_q, state_d;
  logic [AW-1:0]        clr_cnt_q, clr_cnt_d;
  logic                 ready_q, ready_d;
  logic                 collide_q, collide_d;
  logic [NPORTS*DW-1:0] data_out_q;
  logic [NPORTS-1:0]    wr_en_s;
  logic                 clr_wr_s;

  // Next-state logic; a clear request discards that edge's writes.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    wr_en_s   = '0;
    clr_wr_s  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.clr_req) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
          ready_d   = 1'b0;
        end else begin
          ready_d = 1'b1;
          wr_en_s = bus.we;
        end
      end
      ST_CLEAR: begin
        clr_wr_s = 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = ST_RUN;
          clr_cnt_d = '0;
          ready_d   = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
          ready_d   = 1'b0;
        end
      end
      default: begin
        state_d   = ST_RUN;
        clr_cnt_d = '0;
        ready_d   = 1'b1;
      end
    endcase
  end

  // Any pair of accepted writes to one address raises the collision flag.
  always_comb begin
    collide_d = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      for (int q = p + 1; q < NPORTS; q++) begin
        if (wr_en_s[p] && wr_en_s[q] &&
            (bus.addr[p*AW +: AW] == bus.addr[q*AW +: AW])) begin
          collide_d = 1'b1;
        end else begin
          collide_d = collide_d;
        end
      end
    end
  end

  // Control and read-data registers; reads sample the array before this edge's writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RST_STATE;
      clr_cnt_q  <= '0;
      ready_q    <= RST_READY;
      collide_q  <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
      collide_q <= collide_d;
      if (state_q == ST_RUN) begin
        for (int p = 0; p < NPORTS; p++) begin
          data_out_q[p*DW +: DW] <= mem_q[bus.addr[p*AW +: AW]];
        end
      end else begin
        data_out_q <= '0;
      end
    end
  end

  // Storage array; later ports overwrite earlier ones so the highest index wins.
  always_ff @(posedge clk) begin
    if (clr_wr_s) begin
      mem_q[clr_cnt_q] <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (wr_en_s[p]) begin
          mem_q[bus.addr[p*AW +: AW]] <= bus.data_in[p*DW +: DW];
        end
      end
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.ready    = ready_q;
  assign bus.collide  = collide_q;
endmodule
